// File: rtl/mux_channel_scanner_if.sv
// Bus between the channel scanner and the logic that starts scans and consumes results.
// The scanner itself connects through the slave modport.
interface mux_channel_scanner_if;
    logic       i_Start;
    logic       i_Mux_Data;
    logic       o_Sel1;
    logic       o_Sel0;
    logic       o_Busy;
    logic       o_Valid;
    logic [3:0] o_Channels;
    logic [2:0] o_Count;

    modport slave (
        input  i_Start,
        input  i_Mux_Data,
        output o_Sel1,
        output o_Sel0,
        output o_Busy,
        output o_Valid,
        output o_Channels,
        output o_Count
    );

    modport master (
        output i_Start,
        output i_Mux_Data,
        input  o_Sel1,
        input  o_Sel0,
        input  o_Busy,
        input  o_Valid,
        input  o_Channels,
        input  o_Count
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Scans the four inputs of a 4-to-1 mux. Each channel is selected, held for
// SETTLE_CYCLES cycles, then sampled. The snapshot and its popcount are
// published with a one-cycle valid strobe.
module mux_channel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    mux_channel_scanner_if.slave  bus
);

    localparam int unsigned     CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       chan;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       shadow;
    logic [2:0]       run_count;
    logic [1:0]       sel;
    logic             busy;
    logic             valid;
    logic [3:0]       channels;
    logic [2:0]       count;

    assign bus.o_Sel1     = sel[1];
    assign bus.o_Sel0     = sel[0];
    assign bus.o_Busy     = busy;
    assign bus.o_Valid    = valid;
    assign bus.o_Channels = channels;
    assign bus.o_Count    = count;

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: settle on each channel, sample it, finish after channel 3.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.i_Start) next_state = SETTLE;
            SETTLE:  if (cnt == CNT_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = (chan == 2'd3) ? DONE : SETTLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: channel/select stepping, settle timing, sampling and result publish.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            chan      <= '0;
            cnt       <= '0;
            shadow    <= '0;
            run_count <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            channels  <= '0;
            count     <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_Start) begin
                        chan      <= '0;
                        sel       <= '0;
                        cnt       <= '0;
                        shadow    <= '0;
                        run_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                end
                SAMPLE: begin
                    shadow[chan] <= bus.i_Mux_Data;
                    run_count    <= run_count + {2'b00, bus.i_Mux_Data};
                    if (chan != 2'd3) begin
                        chan <= chan + 1'b1;
                        sel  <= chan + 1'b1;
                        cnt  <= '0;
                    end
                end
                DONE: begin
                    channels <= shadow;
                    count    <= run_count;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
